// File: rtl/drum_dot_accumulator.sv
// drum_dot_accumulator: sums unsigned DRUM products over a vector delimited by
// in_last, then holds the saturated sum, beat count and clip flag on a
// valid/ready output until the consumer takes it.
module drum_dot_accumulator #(
  parameter int P     = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P-1:0]     in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sat, sat_nxt;

  // One extra bit so a carry out of the accumulator is visible as overflow.
  logic [ACC_W:0]   sum;
  logic             ovf;
  logic             accept;

  // Beats are only taken while accumulating; flush and reset block the port.
  assign in_ready = (state == ACCUM) && !flush && !rst;
  assign accept   = in_valid && in_ready;

  assign sum = {1'b0, acc} + {{(ACC_W + 1 - P){1'b0}}, in_prod};
  assign ovf = sum[ACC_W];

  // Next-state and accumulator update; defaults hold everything.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sat_nxt   = sat;
    case (state)
      ACCUM: begin
        if (flush) begin
          acc_nxt = '0;
          cnt_nxt = '0;
          sat_nxt = 1'b0;
        end else if (accept) begin
          // Clip to all-ones; once clipped, further beats keep it there.
          acc_nxt = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
          sat_nxt = sat | ovf;
          cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
          if (in_last) state_nxt = HOLD;
        end
      end
      HOLD: begin
        // flush is deliberately ignored here: the result is already committed.
        if (out_ready) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          sat_nxt   = 1'b0;
          state_nxt = ACCUM;
        end
      end
      default: begin
        acc_nxt   = '0;
        cnt_nxt   = '0;
        sat_nxt   = 1'b0;
        state_nxt = ACCUM;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Accumulator, beat counter and sticky clip flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      sat <= sat_nxt;
    end
  end

  // Result is only visible in HOLD; in ACCUM the data outputs read zero.
  assign out_valid = (state == HOLD);
  assign out_data  = out_valid ? acc : '0;
  assign out_count = out_valid ? cnt : '0;
  assign out_sat   = out_valid & sat;

endmodule

// File: tb/tb_drum_dot_accumulator.sv
// Bench for drum_dot_accumulator: directed scenarios plus random traffic,
// checked every cycle against a vector-level reference model.
module tb_drum_dot_accumulator;
  localparam int P     = 8;
  localparam int ACC_W = 10;
  localparam int CNT_W = 4;
  localparam int MAXA  = (1 << ACC_W) - 1;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_last, out_ready;
  logic [P-1:0]     in_prod;
  logic             in_ready, out_valid, out_sat;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  always #5 clk = ~clk;

  drum_dot_accumulator #(.P(P), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_sat(out_sat)
  );

  int total = 0;
  int bad   = 0;

  // Reference: beats of the open vector, and the committed result when held.
  bit m_hold;
  int m_q[$];
  int e_data, e_cnt, e_sat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs mid-cycle, then advance the model on the rising edge.
  task automatic cyc();
    int s;
    @(negedge clk);
    chk("in_ready",  in_ready,  !rst && !m_hold && !flush);
    chk("out_valid", out_valid, m_hold);
    chk("out_data",  out_data,  m_hold ? e_data : 0);
    chk("out_count", out_count, m_hold ? e_cnt  : 0);
    chk("out_sat",   out_sat,   m_hold ? e_sat  : 0);
    @(posedge clk);
    if (rst) begin
      m_hold = 0;
      m_q.delete();
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        m_q.delete();
      end
    end else if (flush) begin
      m_q.delete();
    end else if (in_valid) begin
      m_q.push_back(int'(in_prod));
      if (in_last) begin
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        e_data = (s > MAXA) ? MAXA : s;
        e_cnt  = (m_q.size() > MAXC) ? MAXC : m_q.size();
        e_sat  = (s > MAXA) ? 1 : 0;
        m_hold = 1;
      end
    end
    #1;
  endtask

  task automatic beat(input int p, input bit l);
    in_valid = 1'b1;
    in_prod  = P'(p);
    in_last  = l;
    cyc();
  endtask

  // Direct check of a held result against values worked out by hand.
  task automatic res(input string tag, input int d, input int c, input int s);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"},  out_data,  d);
    chk({tag, "_count"}, out_count, c);
    chk({tag, "_sat"},   out_sat,   s);
  endtask

  task automatic take();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_prod = 8'd50; in_last = 1'b1;
    out_ready = 1'b0;
    m_hold = 0;
    e_data = 0; e_cnt = 0; e_sat = 0;

    // Reset held with traffic present.
    repeat (2) cyc();
    rst = 1'b0; in_valid = 1'b0;
    cyc();
    chk("idle_ready", in_ready, 1);
    cyc();

    // Basic vector.
    beat(6, 0); beat(2, 0); beat(15, 1);
    in_valid = 1'b0;
    res("basic", 23, 3, 0);
    take();

    // Backpressure: result stays put while a beat waits upstream.
    beat(9, 0); beat(9, 1);
    in_valid = 1'b1; in_prod = 8'd7; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", out_data, 18);
      chk("bp_ready", in_ready, 0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_ready", in_ready, 1);
    cyc();                       // the waiting 7 is taken here
    beat(1, 1);
    in_valid = 1'b0;
    res("bp_next", 8, 2, 0);
    take();

    // Saturation.
    for (int i = 0; i < 5; i++) beat(255, i == 4);
    in_valid = 1'b0;
    res("sat", 1023, 5, 1);
    take();

    // Flush wins over a simultaneous beat.
    beat(10, 0); beat(20, 0);
    flush = 1'b1; in_valid = 1'b1; in_prod = 8'd99; in_last = 1'b0;
    cyc();
    flush = 1'b0;
    beat(5, 1);
    in_valid = 1'b0;
    res("flush", 5, 1, 0);
    take();

    // Back-to-back with out_ready tied high: one bubble between vectors.
    out_ready = 1'b1;
    beat(3, 0); beat(4, 1);
    in_valid = 1'b1; in_prod = 8'd1; in_last = 1'b1;
    res("b2b_a", 7, 2, 0);
    cyc();
    chk("b2b_bubble_valid", out_valid, 0);
    chk("b2b_bubble_ready", in_ready, 1);
    cyc();
    res("b2b_b", 1, 1, 0);
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;

    // Beat counter holds at its maximum.
    for (int i = 0; i < 20; i++) beat(1, i == 19);
    in_valid = 1'b0;
    res("cnt_sat", 20, MAXC, 0);
    take();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(63) == 0);
      flush     = ($urandom_range(15) == 0);
      in_valid  = ($urandom_range(3) != 0);
      in_prod   = ($urandom_range(3) == 0) ? 8'd255 : P'($urandom_range(255));
      in_last   = ($urandom_range(5) == 0);
      out_ready = ($urandom_range(1) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
